// File: rtl/alu_issue.sv
// Decode/issue stage feeding the EX-stage ALU: decodes RV32I ALU-class instructions,
// resolves operands through EX/WB forwarding and registers them into the ID/EX register.
`timescale 1ns/1ps
module alu_issue #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic [4:0]        rs1_addr,
    output logic [4:0]        rs2_addr,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              ex_fwd_valid,
    input  logic              ex_fwd_load,
    input  logic [4:0]        ex_fwd_rd,
    input  logic [XLEN-1:0]   ex_fwd_data,
    input  logic              wb_fwd_valid,
    input  logic [4:0]        wb_fwd_rd,
    input  logic [XLEN-1:0]   wb_fwd_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [XLEN-1:0]   alu_data_1,
    output logic [XLEN-1:0]   alu_data_2,
    output logic [4:0]        out_rd,
    output logic              out_rd_we,
    output logic              out_illegal,
    output logic [31:0]       stall_cnt
);
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [CTRL_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [CTRL_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [CTRL_W-1:0] ALU_SLL  = 4'd2;
    localparam logic [CTRL_W-1:0] ALU_SLT  = 4'd3;
    localparam logic [CTRL_W-1:0] ALU_SLTU = 4'd4;
    localparam logic [CTRL_W-1:0] ALU_XOR  = 4'd5;
    localparam logic [CTRL_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [CTRL_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [CTRL_W-1:0] ALU_OR   = 4'd8;
    localparam logic [CTRL_W-1:0] ALU_AND  = 4'd9;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic [XLEN-1:0] src1, src2;

    assign opcode   = in_instr[6:0];
    assign rd       = in_instr[11:7];
    assign funct3   = in_instr[14:12];
    assign funct7   = in_instr[31:25];
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

    // A pending load in EX never forwards: its data does not exist yet (hazard covers it).
    function automatic logic [XLEN-1:0] fwd(input logic [4:0] addr, input logic [XLEN-1:0] rf);
        if (addr == 5'd0)
            return '0;
        else if (ex_fwd_valid && !ex_fwd_load && ex_fwd_rd == addr)
            return ex_fwd_data;
        else if (wb_fwd_valid && wb_fwd_rd == addr)
            return wb_fwd_data;
        else
            return rf;
    endfunction

    assign src1 = fwd(rs1_addr, rs1_data);
    assign src2 = fwd(rs2_addr, rs2_data);

    logic [CTRL_W-1:0] dec_ctrl;
    logic [XLEN-1:0]   dec_d1, dec_d2;
    logic              dec_ill, uses_rs1, uses_rs2, dec_we;

    always_comb begin
        dec_ctrl = ALU_ADD;
        dec_d1   = '0;
        dec_d2   = '0;
        dec_ill  = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OPC_OP: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                dec_d1   = src1;
                dec_d2   = src2;
                case (funct3)
                    3'b000:  dec_ctrl = funct7[5] ? ALU_SUB : ALU_ADD;
                    3'b001:  dec_ctrl = ALU_SLL;
                    3'b010:  dec_ctrl = ALU_SLT;
                    3'b011:  dec_ctrl = ALU_SLTU;
                    3'b100:  dec_ctrl = ALU_XOR;
                    3'b101:  dec_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  dec_ctrl = ALU_OR;
                    default: dec_ctrl = ALU_AND;
                endcase
                if (!(funct7 == 7'b0000000 ||
                      (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
                    dec_ill = 1'b1;
            end
            OPC_OPIMM: begin
                uses_rs1 = 1'b1;
                dec_d1   = src1;
                dec_d2   = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
                case (funct3)
                    3'b000:  dec_ctrl = ALU_ADD;
                    3'b001: begin
                        dec_ctrl = ALU_SLL;
                        dec_d2   = {{(XLEN-5){1'b0}}, in_instr[24:20]};
                        dec_ill  = (funct7 != 7'b0000000);
                    end
                    3'b010:  dec_ctrl = ALU_SLT;
                    3'b011:  dec_ctrl = ALU_SLTU;
                    3'b100:  dec_ctrl = ALU_XOR;
                    3'b101: begin
                        dec_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
                        dec_d2   = {{(XLEN-5){1'b0}}, in_instr[24:20]};
                        dec_ill  = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                    end
                    3'b110:  dec_ctrl = ALU_OR;
                    default: dec_ctrl = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                dec_d2 = {in_instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                dec_d1 = in_pc;
                dec_d2 = {in_instr[31:12], 12'b0};
            end
            default: dec_ill = 1'b1;
        endcase
        // Illegal words issue as a harmless ADD 0,0 and never stall on a load.
        if (dec_ill) begin
            dec_ctrl = ALU_ADD;
            dec_d1   = '0;
            dec_d2   = '0;
            uses_rs1 = 1'b0;
            uses_rs2 = 1'b0;
        end
    end

    assign dec_we = !dec_ill && (rd != 5'd0);

    logic hazard, accept;
    assign hazard = ex_fwd_valid && ex_fwd_load && (ex_fwd_rd != 5'd0) &&
                    ((uses_rs1 && rs1_addr == ex_fwd_rd) || (uses_rs2 && rs2_addr == ex_fwd_rd));

    logic              out_valid_q, out_valid_d;
    logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
    logic [XLEN-1:0]   alu_data_1_q, alu_data_1_d;
    logic [XLEN-1:0]   alu_data_2_q, alu_data_2_d;
    logic [4:0]        out_rd_q, out_rd_d;
    logic              out_rd_we_q, out_rd_we_d;
    logic              out_illegal_q, out_illegal_d;
    logic [31:0]       stall_cnt_q, stall_cnt_d;

    assign in_ready = flush || (!hazard && (!out_valid_q || out_ready));
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        out_valid_d   = out_valid_q;
        alu_ctrl_d    = alu_ctrl_q;
        alu_data_1_d  = alu_data_1_q;
        alu_data_2_d  = alu_data_2_q;
        out_rd_d      = out_rd_q;
        out_rd_we_d   = out_rd_we_q;
        out_illegal_d = out_illegal_q;
        stall_cnt_d   = stall_cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d   = 1'b1;
            alu_ctrl_d    = dec_ctrl;
            alu_data_1_d  = dec_d1;
            alu_data_2_d  = dec_d2;
            out_rd_d      = rd;
            out_rd_we_d   = dec_we;
            out_illegal_d = dec_ill;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (in_valid && hazard && !flush && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            alu_ctrl_q    <= '0;
            alu_data_1_q  <= '0;
            alu_data_2_q  <= '0;
            out_rd_q      <= '0;
            out_rd_we_q   <= 1'b0;
            out_illegal_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            alu_ctrl_q    <= alu_ctrl_d;
            alu_data_1_q  <= alu_data_1_d;
            alu_data_2_q  <= alu_data_2_d;
            out_rd_q      <= out_rd_d;
            out_rd_we_q   <= out_rd_we_d;
            out_illegal_q <= out_illegal_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign alu_ctrl    = alu_ctrl_q;
    assign alu_data_1  = alu_data_1_q;
    assign alu_data_2  = alu_data_2_q;
    assign out_rd      = out_rd_q;
    assign out_rd_we   = out_rd_we_q;
    assign out_illegal = out_illegal_q;
    assign stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: vector table checked through an issue scoreboard, plus
// hand-written load-use, backpressure, flush and reset sequences.
`timescale 1ns/1ps
module tb_alu_issue;
    logic        clk, rst_n, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, rs1_data, rs2_data, ex_fwd_data, wb_fwd_data;
    logic [4:0]  rs1_addr, rs2_addr, ex_fwd_rd, wb_fwd_rd, out_rd;
    logic        ex_fwd_valid, ex_fwd_load, wb_fwd_valid, out_rd_we, out_illegal;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_data_1, alu_data_2, stall_cnt;

    alu_issue dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .ex_fwd_valid(ex_fwd_valid),
        .ex_fwd_load(ex_fwd_load), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
        .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl),
        .alu_data_1(alu_data_1), .alu_data_2(alu_data_2), .out_rd(out_rd),
        .out_rd_we(out_rd_we), .out_illegal(out_illegal), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [31:0] instr, pc, r1, r2;
        logic        exv, exl;
        logic [4:0]  exrd;
        logic [31:0] exd;
        logic        wbv;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic [3:0]  e_ctrl;
        logic [31:0] e_d1, e_d2;
        logic [4:0]  e_rd;
        logic        e_we, e_ill;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[13];
    vec_t mon_e;
    int   n_vec = 0, n_miss = 0, n_txn = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [31:0] instr, pc, r1, r2,
                                input logic exv, exl, input logic [4:0] exrd, input logic [31:0] exd,
                                input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbd,
                                input logic [3:0] c, input logic [31:0] d1, d2,
                                input logic [4:0] rd, input logic we, ill);
        vec_t v;
        v.instr = instr; v.pc = pc; v.r1 = r1; v.r2 = r2;
        v.exv = exv; v.exl = exl; v.exrd = exrd; v.exd = exd;
        v.wbv = wbv; v.wbrd = wbrd; v.wbd = wbd;
        v.e_ctrl = c; v.e_d1 = d1; v.e_d2 = d2; v.e_rd = rd; v.e_we = we; v.e_ill = ill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_instr = v.instr; in_pc = v.pc; rs1_data = v.r1; rs2_data = v.r2;
        ex_fwd_valid = v.exv; ex_fwd_load = v.exl; ex_fwd_rd = v.exrd; ex_fwd_data = v.exd;
        wb_fwd_valid = v.wbv; wb_fwd_rd = v.wbrd; wb_fwd_data = v.wbd;
    endtask

    // Present v until the DUT takes it; expectation is queued in the cycle of acceptance.
    task automatic send(input vec_t v);
        int waited = 0;
        drive(v);
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(v);
                break;
            end
            waited++;
            if (waited > 50) begin
                n_vec++; n_miss++;
                $display("FAIL accept_timeout: instr 0x%08h never accepted", v.instr);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++; n_miss++;
                $display("FAIL unexpected_output: out_valid=1, expected no issue");
            end else begin
                mon_e = sb.pop_front();
                n_txn++;
                $display("txn %0d: instr=0x%08h ctrl=%0d d1=0x%08h d2=0x%08h rd=%0d we=%0b ill=%0b",
                         n_txn, mon_e.instr, alu_ctrl, alu_data_1, alu_data_2, out_rd, out_rd_we, out_illegal);
                chk("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, mon_e.e_ctrl});
                chk("alu_data_1", alu_data_1, mon_e.e_d1);
                chk("alu_data_2", alu_data_2, mon_e.e_d2);
                chk("out_rd", {27'd0, out_rd}, {27'd0, mon_e.e_rd});
                chk("out_rd_we", {31'd0, out_rd_we}, {31'd0, mon_e.e_we});
                chk("out_illegal", {31'd0, out_illegal}, {31'd0, mon_e.e_ill});
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_alu_ctrl"}, {28'd0, alu_ctrl}, 32'd0);
        chk({tag, "_alu_data_1"}, alu_data_1, 32'd0);
        chk({tag, "_alu_data_2"}, alu_data_2, 32'd0);
        chk({tag, "_out_rd"}, {27'd0, out_rd}, 32'd0);
        chk({tag, "_out_rd_we"}, {31'd0, out_rd_we}, 32'd0);
        chk({tag, "_out_illegal"}, {31'd0, out_illegal}, 32'd0);
        chk({tag, "_stall_cnt"}, stall_cnt, 32'd0);
    endtask

    vec_t v_hz, v_lu, v_a, v_b, v_c, v_e, v_auipc;

    initial begin
        //            instr         pc  rs1_data      rs2_data     exv exl exrd  exd        wbv wbrd  wbd       ctrl d1            d2            rd  we ill
        tbl[0]  = mk(32'h00500093, 0, 32'hDEAD,     32'hBEEF,    0, 0, 5'd0,  0,         0, 5'd0,  0,        0, 0,            5,            1,  1, 0);
        tbl[1]  = mk(32'h40208133, 0, 32'h99,       32'h3,       1, 0, 5'd1,  32'h10,    1, 5'd1,  32'h20,   1, 32'h10,       3,            2,  1, 0);
        tbl[2]  = mk(32'h005201B3, 0, 32'h44,       32'h1234,    1, 0, 5'd7,  32'h77,    1, 5'd5,  32'h55,   0, 32'h44,       32'h55,       3,  1, 0);
        tbl[3]  = mk(32'h4033D313, 0, 32'hF0000000, 0,           0, 0, 5'd0,  0,         0, 5'd0,  0,        7, 32'hF0000000, 3,            6,  1, 0);
        tbl[4]  = mk(32'hFFF4A413, 0, 32'h5,        0,           0, 0, 5'd0,  0,         0, 5'd0,  0,        3, 32'h5,        32'hFFFFFFFF, 8,  1, 0);
        tbl[5]  = mk(32'hABCDE537, 0, 32'h1111,     32'h2222,    0, 0, 5'd0,  0,         0, 5'd0,  0,        0, 0,            32'hABCDE000, 10, 1, 0);
        tbl[6]  = mk(32'hFE0000B3, 0, 32'h1,        32'h2,       0, 0, 5'd0,  0,         0, 5'd0,  0,        0, 0,            0,            1,  0, 1);
        tbl[7]  = mk(32'h02001093, 0, 32'h1,        32'h2,       0, 0, 5'd0,  0,         0, 5'd0,  0,        0, 0,            0,            1,  0, 1);
        tbl[8]  = mk(32'h00208033, 0, 32'h7,        32'h8,       0, 0, 5'd0,  0,         0, 5'd0,  0,        0, 32'h7,        32'h8,        0,  0, 0);
        tbl[9]  = mk(32'h00D675B3, 0, 32'h0F0F,     0,           1, 0, 5'd13, 32'hAAAA,  1, 5'd13, 32'hBBBB, 9, 32'h0F0F,     32'hAAAA,     11, 1, 0);
        tbl[10] = mk(32'h40209133, 0, 32'h1,        32'h2,       0, 0, 5'd0,  0,         0, 5'd0,  0,        0, 0,            0,            2,  0, 1);
        tbl[11] = mk(32'h003130B3, 0, 32'h1,        32'h2,       0, 0, 5'd0,  0,         0, 5'd0,  0,        4, 32'h1,        32'h2,        1,  1, 0);
        tbl[12] = mk(32'h000080B7, 0, 32'h5,        32'h6,       1, 1, 5'd1,  32'h999,   0, 5'd0,  0,        0, 0,            32'h00008000, 1,  1, 0);

        v_hz    = mk(32'h001001B3, 0, 0, 0,         1, 1, 5'd1, 32'h999, 0, 5'd0, 0,        0, 0, 0, 3, 1, 0);
        v_lu    = mk(32'h001001B3, 0, 32'h4, 32'h5, 0, 0, 5'd0, 0,       1, 5'd1, 32'h321,  0, 0, 32'h321, 3, 1, 0);
        v_a     = mk(32'h0020C233, 0, 32'h0FF0, 32'h00FF, 0, 0, 5'd0, 0, 0, 5'd0, 0,       5, 32'h0FF0, 32'h00FF, 4, 1, 0);
        v_b     = mk(32'h0020E2B3, 0, 32'h100, 32'h1, 0, 0, 5'd0, 0,     0, 5'd0, 0,       8, 32'h100, 32'h1, 5, 1, 0);
        v_c     = mk(32'h0020D333, 0, 32'h80, 32'h2, 0, 0, 5'd0, 0,      0, 5'd0, 0,       6, 32'h80, 32'h2, 6, 1, 0);
        v_e     = mk(32'h002093B3, 0, 32'h3, 32'h4, 0, 0, 5'd0, 0,       0, 5'd0, 0,       2, 32'h3, 32'h4, 7, 1, 0);
        v_auipc = mk(32'h00001117, 32'h100, 32'h77, 32'h88, 0, 0, 5'd0, 0, 0, 5'd0, 0,     0, 32'h100, 32'h1000, 2, 1, 0);

        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst_n = 1'b1;
        idle(1);

        for (int i = 0; i < 13; i++) send(tbl[i]);
        idle(2);

        // Load-use: x1 pending in EX as a load, consumer reads x1 as rs2.
        drive(v_hz);
        in_valid = 1'b1;
        @(negedge clk);
        chk("loaduse_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("loaduse_bubble", {31'd0, out_valid}, 32'd0);
        chk("loaduse_stall_cnt", stall_cnt, 32'd1);
        send(v_lu);
        idle(2);
        chk("loaduse_stall_after", stall_cnt, 32'd1);

        // Backpressure: A held for three cycles while B waits.
        out_ready = 1'b0;
        send(v_a);
        drive(v_b);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_alu_ctrl", {28'd0, alu_ctrl}, 32'd5);
            chk("hold_data_1", alu_data_1, 32'h0FF0);
            chk("hold_data_2", alu_data_2, 32'h00FF);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(v_b);
        idle(2);

        // Flush while an instruction is held and a hazarding one is offered.
        out_ready = 1'b0;
        send(v_c);
        drive(v_hz);
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_stall_cnt", stall_cnt, 32'd1);
        void'(sb.pop_back());

        // Reset mid-stream: held instruction plus six more stall cycles.
        send(v_e);
        drive(v_hz);
        in_valid = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        chk("pre_reset_stall_cnt", stall_cnt, 32'd7);
        chk("pre_reset_out_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk_reset_state("midreset");
        sb.delete();
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(v_auipc);
        idle(3);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
